// File: rtl/imem_fetch_controller.sv
// rtl/imem_fetch_controller.sv - instruction fetch sequencer with circular prefetch queue
// Owns the fetch PC, captures combinational imem words into the queue, flushes on redirect/exception.
module imem_fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'hF000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_en,
    output logic [31:0]             imem_addr,
    input  logic [31:0]             imem_data,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    input  logic                    exception,
    output logic                    inst_valid,
    output logic [31:0]             inst,
    output logic [31:0]             inst_pc,
    input  logic                    inst_ready,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    fetch_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic            r_fault;
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_q_inst [DEPTH];
    logic [31:0]     r_q_pc   [DEPTH];

    logic            w_flush;
    logic            w_pop;
    logic            w_full;
    logic            w_push;

    assign w_flush = exception | redirect_valid;
    assign w_pop   = (r_count != '0) & inst_ready & ~w_flush;
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = (r_state == S_RUN) & fetch_en & ~w_flush & (~w_full | w_pop);

    // Head is a mux of queue registers only, so decode never sees imem_data combinationally.
    assign imem_addr   = r_fetch_pc;
    assign inst_valid  = (r_count != '0);
    assign inst        = r_q_inst[r_head];
    assign inst_pc     = r_q_pc[r_head];
    assign occupancy   = r_count;
    assign fetch_fault = r_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_fetch_pc <= RESET_PC;
            r_fault    <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_inst[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else if (exception) begin
            r_state    <= S_RUN;
            r_fetch_pc <= EXC_VECTOR;
            r_fault    <= 1'b0;
            r_head     <= r_tail;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_head     <= r_tail;
            r_count    <= '0;
            if (redirect_pc[1:0] != 2'b00) begin
                r_state <= S_FAULT;
                r_fault <= 1'b1;
            end else begin
                r_state <= S_RUN;
                r_fault <= 1'b0;
            end
        end else begin
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            if (w_push) begin
                r_q_inst[r_tail] <= imem_data;
                r_q_pc[r_tail]   <= r_fetch_pc;
                r_tail           <= r_tail + AW'(1);
                r_fetch_pc       <= r_fetch_pc + 32'd4;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_controller.sv
// tb/tb_imem_fetch_controller.sv - scenario tasks plus randomized run against a queue-based fetch model
module tb_imem_fetch_controller;

    localparam int          DEPTH = 2;
    localparam logic [31:0] EXC   = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic        exception = 1'b0;
    logic        inst_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr, imem_data, inst, inst_pc;
    logic        inst_valid, fetch_fault;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    entry_t      q[$];
    logic [31:0] m_pc;
    logic        m_fault;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h3408_0032;
            32'h0000_0004: return 32'hac08_0000;
            32'h0000_0008: return 32'h3408_0028;
            32'h0000_0190: return 32'hac09_0054;
            32'hF000_0000: return 32'h8c08_0000;
            32'h0000_0500: return 32'h240d_0000;
            default:       return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
        endcase
    endfunction

    assign imem_data = mem_word(imem_addr);

    imem_fetch_controller #(
        .RESET_PC  (32'h0000_0000),
        .EXC_VECTOR(EXC),
        .DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .exception     (exception),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .occupancy     (occupancy),
        .fetch_fault   (fetch_fault)
    );

    task automatic model_reset();
        q.delete();
        m_pc    = 32'h0;
        m_fault = 1'b0;
    endtask

    // Advance the model by the rules for one edge, then clock the DUT and settle.
    task automatic tick();
        entry_t e;
        bit     pop, push;
        if (exception) begin
            q.delete();
            m_pc    = EXC;
            m_fault = 1'b0;
        end else if (redirect_valid) begin
            q.delete();
            m_pc    = redirect_pc;
            m_fault = (redirect_pc % 4) != 0;
        end else begin
            pop  = (q.size() > 0) && inst_ready;
            push = !m_fault && fetch_en && ((q.size() < DEPTH) || pop);
            e.pc  = m_pc;
            e.ins = mem_word(m_pc);
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic fe, input logic rdy);
        fetch_en       = fe;
        inst_ready     = rdy;
        redirect_valid = 1'b0;
        exception      = 1'b0;
        reset          = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b1);
        checks++;
        if (inst_valid !== 1'b0 || occupancy !== 2'd0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b occ=%0d inst=%h pc=%h, want 0/0/0/0", inst_valid, occupancy, inst, inst_pc);
        end
        checks++;
        if (imem_addr !== 32'h0 || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_pc: imem_addr=%h fault=%b, want 00000000/0", imem_addr, fetch_fault);
        end
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] ins [3] = '{32'h3408_0032, 32'hac08_0000, 32'h3408_0028};
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== pcs[i] || inst !== ins[i] || occupancy !== 2'd1) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b pc=%h inst=%h occ=%0d, want 1/%h/%h/1", i, inst_valid, inst_pc, inst, occupancy, pcs[i], ins[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ins [3] = '{32'h3408_0032, 32'hac08_0000, 32'h3408_0028};
        do_reset(1'b1, 1'b0);
        tick();
        tick();
        checks++;
        if (occupancy !== 2'd2 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL backpressure_full: occ=%0d addr=%h, want 2/00000008", occupancy, imem_addr);
        end
        tick();
        checks++;
        if (occupancy !== 2'd2 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL backpressure_hold: occ=%0d addr=%h, want 2/00000008", occupancy, imem_addr);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst !== ins[i] || inst_pc !== 32'(i * 4)) begin
                errors++;
                $display("FAIL drain[%0d]: valid=%b inst=%h pc=%h, want 1/%h/%h", i, inst_valid, inst, inst_pc, ins[i], 32'(i * 4));
            end
            tick();
        end
    endtask

    task automatic test_redirect_full();
        inst_ready = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h190;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || occupancy !== 2'd0 || imem_addr !== 32'h190) begin
            errors++;
            $display("FAIL redirect_flush: valid=%b occ=%0d addr=%h, want 0/0/00000190", inst_valid, occupancy, imem_addr);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h190 || inst !== 32'hac09_0054) begin
            errors++;
            $display("FAIL redirect_target: valid=%b pc=%h inst=%h, want 1/00000190/ac090054", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_exc_priority();
        inst_ready     = 1'b1;
        exception      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h180;
        tick();
        exception      = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd0 || imem_addr !== EXC) begin
            errors++;
            $display("FAIL exc_flush: occ=%0d addr=%h, want 0/%h", occupancy, imem_addr, EXC);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== EXC || inst !== 32'h8c08_0000) begin
            errors++;
            $display("FAIL exc_target: valid=%b pc=%h inst=%h, want 1/%h/8c080000", inst_valid, inst_pc, inst, EXC);
        end
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h182;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (fetch_fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_set: fault=%b, want 1", fetch_fault);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b0 || imem_addr !== 32'h182 || fetch_fault !== 1'b1) begin
                errors++;
                $display("FAIL fault_hold[%0d]: valid=%b addr=%h fault=%b, want 0/00000182/1", i, inst_valid, imem_addr, fetch_fault);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (fetch_fault !== 1'b0 || imem_addr !== 32'h500) begin
            errors++;
            $display("FAIL fault_clear: fault=%b addr=%h, want 0/00000500", fetch_fault, imem_addr);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h240d_0000 || inst_pc !== 32'h500) begin
            errors++;
            $display("FAIL fault_resume: valid=%b inst=%h pc=%h, want 1/240d0000/00000500", inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pcs [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== pcs[i] || inst !== mem_word(pcs[i]) || fetch_fault !== 1'b0) begin
                errors++;
                $display("FAIL wrap[%0d]: valid=%b pc=%h inst=%h fault=%b, want 1/%h/%h/0", i, inst_valid, inst_pc, inst, fetch_fault, pcs[i], mem_word(pcs[i]));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1, 1'b0);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || occupancy !== 2'd0 || inst !== 32'h0 || inst_pc !== 32'h0 ||
            imem_addr !== 32'h0 || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b occ=%0d inst=%h pc=%h addr=%h fault=%b, want all zero",
                     inst_valid, occupancy, inst, inst_pc, imem_addr, fetch_fault);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h3408_0032) begin
            errors++;
            $display("FAIL async_restart: valid=%b pc=%h inst=%h, want 1/00000000/34080032", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_random();
        int r;
        do_reset(1'b1, 1'b1);
        for (int n = 0; n < 600; n++) begin
            fetch_en       = ($urandom_range(0, 9) < 8);
            inst_ready     = ($urandom_range(0, 9) < 6);
            exception      = ($urandom_range(0, 99) < 3);
            redirect_valid = ($urandom_range(0, 99) < 8);
            r = $urandom_range(0, 9);
            if (r < 6)      redirect_pc = $urandom & 32'hFFFF_FFFC;
            else if (r < 8) redirect_pc = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
            else            redirect_pc = $urandom | 32'h1;
            tick();
            checks++;
            if (occupancy !== 2'(q.size()) || inst_valid !== (q.size() > 0) ||
                imem_addr !== m_pc || fetch_fault !== m_fault) begin
                errors++;
                $display("FAIL rand_state[%0d]: occ=%0d valid=%b addr=%h fault=%b, want %0d/%b/%h/%b",
                         n, occupancy, inst_valid, imem_addr, fetch_fault, q.size(), q.size() > 0, m_pc, m_fault);
            end
            if (q.size() > 0) begin
                checks++;
                if (inst !== q[0].ins || inst_pc !== q[0].pc) begin
                    errors++;
                    $display("FAIL rand_head[%0d]: inst=%h pc=%h, want %h/%h", n, inst, inst_pc, q[0].ins, q[0].pc);
                end
            end
        end
        exception      = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_exc_priority();
        test_fault();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
